// File: rtl/neural_pkg.sv
// Shared types and constants for the time-multiplexed neural layer sequencer.
package neural_pkg;

  localparam int WIDTH = 16;
  localparam logic [15:0] Q88_ONE = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/neural_coeff_rf.sv
// Coefficient pair register file: one write port, one asynchronous read port,
// asynchronous active-low clear. Out-of-range write addresses are dropped.
module neural_coeff_rf
  import neural_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int N  = 8,
  parameter int AW = $clog2(N),
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          w_en_i,
  input  logic [AW-1:0] w_addr_i,
  input  logic [W-1:0]  w_coeff_a_i,
  input  logic [W-1:0]  w_coeff_b_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_coeff_a_o,
  output logic [W-1:0]  rd_coeff_b_o
);

  logic [2*W-1:0] mem_q [N];

  // Address match against every entry doubles as the range guard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_en_i && (32'(w_addr_i) == k)) mem_q[k] <= {w_coeff_a_i, w_coeff_b_i};
      end
    end
  end

  assign {rd_coeff_a_o, rd_coeff_b_o} = mem_q[rd_idx_i];

endmodule

// File: rtl/neural_layer_seq.sv
// Sequencer feeding one two-input neuron with N coefficient pairs per input pair,
// gathering the fire bits into an N-bit result offered over valid/ready.
module neural_layer_seq
  import neural_pkg::*;
#(
  parameter int WIDTH = neural_pkg::WIDTH,
  parameter int N     = 8,
  parameter int AW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_coeff_a,
  input  logic [WIDTH-1:0] w_coeff_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] neu_input_a,
  output logic [WIDTH-1:0] neu_input_b,
  output logic [WIDTH-1:0] neu_coeff_a,
  output logic [WIDTH-1:0] neu_coeff_b,
  input  logic             neu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_bits,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(N);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; res_valid/res_bits hold until taken, in_ready is only high in IDLE.
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
  logic [N-1:0]     res_bits_q, res_bits_d;
  logic [WIDTH-1:0] rf_coeff_a, rf_coeff_b;

  neural_coeff_rf #(.W(WIDTH), .N(N), .AW(AW), .IW(IW)) u_coeff_rf (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .w_en_i       (w_en),
    .w_addr_i     (w_addr),
    .w_coeff_a_i  (w_coeff_a),
    .w_coeff_b_i  (w_coeff_b),
    .rd_idx_i     (idx_q),
    .rd_coeff_a_o (rf_coeff_a),
    .rd_coeff_b_o (rf_coeff_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      res_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      res_bits_q <= res_bits_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    res_bits_d  = res_bits_q;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    neu_input_a = '0;
    neu_input_b = '0;
    neu_coeff_a = '0;
    neu_coeff_b = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_a_d  = in_a;
          in_b_d  = in_b;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        neu_input_a        = in_a_q;
        neu_input_b        = in_b_q;
        neu_coeff_a        = rf_coeff_a;
        neu_coeff_b        = rf_coeff_b;
        res_bits_d[idx_q]  = neu_out;
        idx_d              = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign res_bits  = res_bits_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_neural_layer_seq.sv
// Directed bench for neural_layer_seq with a behavioural two-input neuron attached.
module tb_neural_layer_seq;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [W-1:0]  w_coeff_a = '0, w_coeff_b = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [W-1:0]  neu_input_a, neu_input_b, neu_coeff_a, neu_coeff_b;
  logic          neu_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [N-1:0]  res_bits;
  logic          busy;
  logic [1:0]    dbg_state;

  int passed = 0;
  int total  = 0;

  neural_layer_seq #(.WIDTH(W), .N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr),
    .w_coeff_a(w_coeff_a), .w_coeff_b(w_coeff_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .neu_input_a(neu_input_a), .neu_input_b(neu_input_b),
    .neu_coeff_a(neu_coeff_a), .neu_coeff_b(neu_coeff_b),
    .neu_out(neu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_bits(res_bits), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Neuron: fires when a*ca + b*cb (signed) is strictly positive.
  logic signed [32:0] pa, pb, psum;
  always_comb begin
    pa      = 33'($signed(neu_input_a)) * 33'($signed(neu_coeff_a));
    pb      = 33'($signed(neu_input_b)) * 33'($signed(neu_coeff_b));
    psum    = pa + pb;
    neu_out = (psum > 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coeff(input logic [AW-1:0] addr, input logic [W-1:0] a, input logic [W-1:0] b);
    w_en = 1'b1; w_addr = addr; w_coeff_a = a; w_coeff_b = b;
    tick();
    w_en = 1'b0;
  endtask

  // One evaluation; optionally writes neuron 5 := (FF00,0) after wr_after ticks past accept.
  task automatic do_eval(input logic [W-1:0] a, input logic [W-1:0] b, input int wr_after,
                         output logic [N-1:0] bits, output int lat);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    bits = 'x;
    for (int i = 0; i < 20; i++) begin
      if (lat == wr_after) begin
        w_en = 1'b1; w_addr = 4'd5; w_coeff_a = 16'hFF00; w_coeff_b = 16'h0000;
      end
      tick();
      w_en = 1'b0;
      lat++;
      if (res_valid) break;
    end
    if (res_valid) bits = res_bits;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_bits !== '0 || dbg_state !== 2'd0)
      $display("FAIL reset_outputs: in_ready=%b res_valid=%b busy=%b res_bits=%h state=%0d, want 1 0 0 00 0",
               in_ready, res_valid, busy, res_bits, dbg_state);
    else passed++;
    total++;
    if ({neu_input_a, neu_input_b, neu_coeff_a, neu_coeff_b} !== '0)
      $display("FAIL reset_neu: neu operands=%h, want 0", {neu_input_a, neu_input_b, neu_coeff_a, neu_coeff_b});
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic saw_valid;
    write_coeff(4'd0, 16'h0100, 16'h0000);
    in_a = 16'h0100; in_b = 16'h0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b1 || neu_input_a !== 16'h0100)
      $display("FAIL mid_run_pre: busy=%b neu_input_a=%h, want 1 0100", busy, neu_input_a);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_bits !== '0 ||
        {neu_input_a, neu_input_b, neu_coeff_a, neu_coeff_b} !== '0)
      $display("FAIL mid_run_reset: res_valid=%b in_ready=%b res_bits=%h neu=%h, want 0 1 00 0",
               res_valid, in_ready, res_bits, {neu_input_a, neu_input_b, neu_coeff_a, neu_coeff_b});
    else passed++;
    tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0) $display("FAIL mid_run_no_result: res_valid seen=%b, want 0", saw_valid);
    else passed++;
  endtask

  task automatic load_alternating();
    for (int k = 0; k < N; k++)
      write_coeff(AW'(k), (k % 2 == 0) ? 16'h0100 : 16'hFF00, 16'h0000);
  endtask

  task automatic test_pattern();
    logic [N-1:0] bits;
    int lat;
    load_alternating();
    do_eval(16'h0100, 16'h0000, -1, bits, lat);
    total++;
    if (bits !== 8'b01010101) $display("FAIL pattern_pos: res_bits=%b, want 01010101", bits);
    else passed++;
    total++;
    if (lat !== 8) $display("FAIL pattern_latency: cycles=%0d, want 8", lat);
    else passed++;
    do_eval(16'hFF00, 16'h0000, -1, bits, lat);
    total++;
    if (bits !== 8'b10101010) $display("FAIL pattern_neg: res_bits=%b, want 10101010", bits);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic ok_stable;
    in_a = 16'h0100; in_b = 16'h0000; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      tick();
    end
    ok_stable = res_valid;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_bits !== 8'h55 || in_ready !== 1'b0) ok_stable = 1'b0;
      tick();
    end
    total++;
    if (ok_stable !== 1'b1 || res_bits !== 8'h55)
      $display("FAIL backpressure_hold: stable=%b res_bits=%h, want 1 55", ok_stable, res_bits);
    else passed++;
    res_ready = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL backpressure_release: busy=%b in_ready=%b res_valid=%b, want 0 1 0", busy, in_ready, res_valid);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b1 || dbg_state !== 2'd1)
      $display("FAIL backpressure_accept: busy=%b state=%0d, want 1 1", busy, dbg_state);
    else passed++;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_t[$];
    logic prev_busy;
    logic bits_ok;
    int nvalid;
    in_a = 16'h0100; in_b = 16'h0000; in_valid = 1'b1; res_ready = 1'b1;
    w_en = 1'b1; w_addr = 4'd9; w_coeff_a = 16'h0100; w_coeff_b = 16'h0100;
    prev_busy = busy;
    bits_ok = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      w_en = 1'b0;
      if (busy && !prev_busy) acc_t.push_back(i);
      if (res_valid) begin
        nvalid++;
        if (res_bits !== 8'h55) bits_ok = 1'b0;
      end
      prev_busy = busy;
      if (acc_t.size() == 3) break;
    end
    in_valid = 1'b0;
    total++;
    if (acc_t.size() != 3 || acc_t[1] - acc_t[0] != 10 || acc_t[2] - acc_t[1] != 10)
      $display("FAIL b2b_spacing: accepts=%0d gaps=%0d,%0d, want 3 10,10", acc_t.size(),
               (acc_t.size() > 1) ? acc_t[1] - acc_t[0] : -1, (acc_t.size() > 2) ? acc_t[2] - acc_t[1] : -1);
    else passed++;
    total++;
    if (bits_ok !== 1'b1 || nvalid != 2)
      $display("FAIL b2b_bits_addr9: bits_ok=%b results=%0d, want 1 2", bits_ok, nvalid);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_write_during_run();
    logic [N-1:0] bits;
    int lat;
    for (int k = 0; k < N; k++) write_coeff(AW'(k), 16'h0100, 16'h0000);
    do_eval(16'h0100, 16'h0000, 5, bits, lat);
    total++;
    if (bits !== 8'hFF) $display("FAIL write_same_edge: res_bits=%b, want 11111111", bits);
    else passed++;
    write_coeff(4'd5, 16'h0100, 16'h0000);
    do_eval(16'h0100, 16'h0000, 4, bits, lat);
    total++;
    if (bits !== 8'hDF) $display("FAIL write_early: res_bits=%b, want 11011111", bits);
    else passed++;
  endtask

  task automatic test_zero_coeffs();
    logic [N-1:0] bits;
    int lat;
    for (int k = 0; k < N; k++) write_coeff(AW'(k), 16'h0000, 16'h0000);
    do_eval(16'h0100, 16'h0100, -1, bits, lat);
    total++;
    if (bits !== 8'h00) $display("FAIL zero_coeffs: res_bits=%b, want 00000000", bits);
    else passed++;
    total++;
    if (lat !== 8) $display("FAIL zero_latency: cycles=%0d, want 8", lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_pattern();
    test_backpressure();
    test_back_to_back();
    test_write_during_run();
    test_zero_coeffs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
